// File: rtl/vc_credit_buffer.sv
// rtl/vc_credit_buffer.sv - multi-channel credit FIFO with round-robin drain; VC_CREDIT_BUFFER_HWM_EN adds high-water marks
module vc_credit_buffer #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [CH_W-1:0]         in_ch,
    input  logic [WIDTH-1:0]        in_data,
    output logic [NUM_CH*CNT_W-1:0] in_credit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch,
    output logic [WIDTH-1:0]        out_data,
    output logic                    ovf_err
`ifdef VC_CREDIT_BUFFER_HWM_EN
    ,
    input  logic                    hwm_clr,
    output logic [NUM_CH*CNT_W-1:0] hwm
`endif
);

    localparam int MEM_N  = NUM_CH * DEPTH;
    localparam int MEM_AW = (MEM_N > 1) ? $clog2(MEM_N) : 1;
    localparam logic [CNT_W-1:0]  FULL_CR  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [MEM_N];
    logic [CNT_W-1:0]  credit     [NUM_CH];
    logic [CNT_W-1:0]  credit_nxt [NUM_CH];
    logic [ADDR_W-1:0] wr_ptr     [NUM_CH];
    logic [ADDR_W-1:0] rd_ptr     [NUM_CH];

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   srch;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] gnt_hit;
    logic              wr_fire;
    logic              gnt_any;
    logic              grant;
    logic [MEM_AW-1:0] wr_addr;
    logic [MEM_AW-1:0] rd_addr;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    // Illegal channel numbers match no wr_hit bit, so they fall through to ovf_err.
    always_comb begin
        wr_hit  = '0;
        wr_addr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_valid && (in_ch == CH_W'(c)) && (credit[c] != '0)) begin
                wr_hit[c] = 1'b1;
                wr_addr   = MEM_AW'(c * DEPTH) + MEM_AW'(wr_ptr[c]);
            end
        end
        wr_fire = |wr_hit;
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        srch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            srch = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!gnt_any && (credit[srch] != FULL_CR)) begin
                gnt_any = 1'b1;
                gnt_ch  = srch;
            end
        end
        grant = gnt_any && (!out_valid || out_ready);
    end

    always_comb begin
        gnt_hit = '0;
        rd_addr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant && (gnt_ch == CH_W'(c))) begin
                gnt_hit[c] = 1'b1;
            end
            if (gnt_ch == CH_W'(c)) begin
                rd_addr = MEM_AW'(c * DEPTH) + MEM_AW'(rd_ptr[c]);
            end
        end
    end

    // A write and a grant on the same channel cancel out in the credit count.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            credit_nxt[c] = credit[c];
            if (wr_hit[c] && !gnt_hit[c]) begin
                credit_nxt[c] = credit[c] - CNT_W'(1);
            end else if (!wr_hit[c] && gnt_hit[c]) begin
                credit_nxt[c] = credit[c] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                credit[c] <= FULL_CR;
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                credit[c] <= credit_nxt[c];
                if (wr_hit[c]) begin
                    wr_ptr[c] <= ptr_inc(wr_ptr[c]);
                end
                if (gnt_hit[c]) begin
                    rd_ptr[c] <= ptr_inc(rd_ptr[c]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            rr_ptr    <= '0;
            ovf_err   <= 1'b0;
        end else begin
            if (in_valid && !wr_fire) begin
                ovf_err <= 1'b1;
            end
            if (grant) begin
                out_valid <= 1'b1;
                out_ch    <= gnt_ch;
                out_data  <= mem[rd_addr];
                rr_ptr    <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        in_credit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            in_credit[c*CNT_W +: CNT_W] = credit[c];
        end
    end

`ifdef VC_CREDIT_BUFFER_HWM_EN
    logic [CNT_W-1:0] hwm_r [NUM_CH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hwm_r[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hwm_clr) begin
                    hwm_r[c] <= FULL_CR - credit[c];
                end else if ((FULL_CR - credit_nxt[c]) > hwm_r[c]) begin
                    hwm_r[c] <= FULL_CR - credit_nxt[c];
                end
            end
        end
    end

    always_comb begin
        hwm = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hwm[c*CNT_W +: CNT_W] = hwm_r[c];
        end
    end
`endif

endmodule
